// File: rtl/csr_index_stream_reader.sv
// CSR index reader: fetches the row_ptr word and column-index words from SRAM1
// and streams packed column indices one per beat over valid/ready.
module csr_index_stream_reader #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 5,
    parameter int RP_W    = 136,
    parameter int CI_W    = 4,
    parameter int CNT_W   = 12,
    parameter int RP_ADDR = 0,
    parameter int CI_BASE = 1,
    parameter int RD_LAT  = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_nnz,
    input  logic [DATA_W-1:0] i_read_data,
    output logic              o_read_en,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic [RP_W-1:0]   o_row_ptr,
    output logic              o_rp_valid,
    output logic [CI_W-1:0]   o_col_idx,
    output logic              o_ci_valid,
    input  logic              i_ci_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_state
);
    localparam int CPW    = DATA_W / CI_W;
    localparam int SLOT_W = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CPW - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RP_RD   = 3'd1,
        RP_WAIT = 3'd2,
        CI_RD   = 3'd3,
        CI_WAIT = 3'd4,
        STREAM  = 3'd5,
        DONE    = 3'd6
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             nnz_q, nnz_d;
    logic [CNT_W-1:0]             sent_q, sent_d;
    logic [ADDR_W-1:0]            word_q, word_d;
    logic [SLOT_W-1:0]            slot_q, slot_d;
    logic [LAT_W-1:0]             lat_q, lat_d;
    logic [RP_W-1:0]              row_ptr_q, row_ptr_d;
    logic                         rp_valid_q, rp_valid_d;
    logic [CPW-1:0][CI_W-1:0]     ci_buf_q, ci_buf_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            nnz_q      <= '0;
            sent_q     <= '0;
            word_q     <= '0;
            slot_q     <= '0;
            lat_q      <= '0;
            row_ptr_q  <= '0;
            rp_valid_q <= 1'b0;
            ci_buf_q   <= '0;
        end else begin
            state_q    <= state_d;
            nnz_q      <= nnz_d;
            sent_q     <= sent_d;
            word_q     <= word_d;
            slot_q     <= slot_d;
            lat_q      <= lat_d;
            row_ptr_q  <= row_ptr_d;
            rp_valid_q <= rp_valid_d;
            ci_buf_q   <= ci_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nnz_d      = nnz_q;
        sent_d     = sent_q;
        word_d     = word_q;
        slot_d     = slot_q;
        lat_d      = lat_q;
        row_ptr_d  = row_ptr_q;
        rp_valid_d = rp_valid_q;
        ci_buf_d   = ci_buf_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    nnz_d      = i_nnz;
                    rp_valid_d = 1'b0;
                    word_d     = '0;
                    slot_d     = '0;
                    sent_d     = '0;
                    state_d    = RP_RD;
                end
            end
            RP_RD: begin
                lat_d   = '0;
                state_d = RP_WAIT;
            end
            // Read data is only sampled on the final wait cycle, RD_LAT after the strobe.
            RP_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    row_ptr_d  = i_read_data[RP_W-1:0];
                    rp_valid_d = 1'b1;
                    lat_d      = '0;
                    state_d    = (nnz_q == '0) ? DONE : CI_RD;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            CI_RD: begin
                lat_d   = '0;
                state_d = CI_WAIT;
            end
            CI_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    ci_buf_d = i_read_data;
                    lat_d    = '0;
                    state_d  = STREAM;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            STREAM: begin
                if (i_ci_ready) begin
                    sent_d = sent_q + CNT_W'(1);
                    slot_d = slot_q + SLOT_W'(1);
                    if (sent_q + CNT_W'(1) == nnz_q) begin
                        state_d = DONE;
                    end else if (slot_q == SLOT_LAST) begin
                        slot_d  = '0;
                        word_d  = word_q + ADDR_W'(1);
                        state_d = CI_RD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode registered state only; i_ci_ready never reaches them directly.
    always_comb begin
        o_read_en   = 1'b0;
        o_read_addr = '0;
        case (state_q)
            RP_RD: begin
                o_read_en   = 1'b1;
                o_read_addr = ADDR_W'(RP_ADDR);
            end
            CI_RD: begin
                o_read_en   = 1'b1;
                o_read_addr = ADDR_W'(CI_BASE) + word_q;
            end
            default: ;
        endcase
    end

    assign o_ci_valid = (state_q == STREAM);
    assign o_col_idx  = (state_q == STREAM) ? ci_buf_q[slot_q] : '0;
    assign o_row_ptr  = row_ptr_q;
    assign o_rp_valid = rp_valid_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_state    = state_q;

endmodule

// File: tb/tb_csr_index_stream_reader.sv
// Directed bench for csr_index_stream_reader: one instance at RD_LAT=1 and one at RD_LAT=3,
// each fed by a small SRAM model; expected streams come from a nibble-pattern function.
module tb_csr_index_stream_reader;
    localparam int DW  = 256;
    localparam int AW  = 5;
    localparam int RPW = 136;
    localparam int CIW = 4;
    localparam int CW  = 12;
    localparam logic [DW-1:0]  FILL   = {32{8'hEE}};
    localparam logic [RPW-1:0] EXP_RP = {17{8'hA5}};

    logic          clk, rst_n, start1, start3, ready, sel;
    logic [CW-1:0] nnz_in;
    logic [DW-1:0] mem [0:31];

    logic [DW-1:0]  rd1, rd3, s1_3, s2_3;
    logic           re1, re3, rpv1, rpv3, civ1, civ3, busy1, busy3, done1, done3;
    logic [AW-1:0]  ra1, ra3;
    logic [RPW-1:0] rp1, rp3;
    logic [CIW-1:0] ci1, ci3;
    logic [2:0]     st1, st3;

    logic           o_re, o_rpv, o_civ, o_busy, o_done;
    logic [AW-1:0]  o_ra;
    logic [RPW-1:0] o_rp;
    logic [CIW-1:0] o_ci;
    logic [2:0]     o_st;

    int n_chk = 0;
    int n_err = 0;

    int             rd_cyc[$];
    int             rd_addr[$];
    logic [CIW-1:0] beats[$];
    int             first_rpv, first_civ, done_cyc, civ_cycles;

    csr_index_stream_reader #(.RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rstn(rst_n), .i_start(start1), .i_nnz(nnz_in),
        .i_read_data(rd1), .o_read_en(re1), .o_read_addr(ra1), .o_row_ptr(rp1),
        .o_rp_valid(rpv1), .o_col_idx(ci1), .o_ci_valid(civ1), .i_ci_ready(ready),
        .o_busy(busy1), .o_done(done1), .o_state(st1)
    );

    csr_index_stream_reader #(.RD_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rstn(rst_n), .i_start(start3), .i_nnz(nnz_in),
        .i_read_data(rd3), .o_read_en(re3), .o_read_addr(ra3), .o_row_ptr(rp3),
        .o_rp_valid(rpv3), .o_col_idx(ci3), .o_ci_valid(civ3), .i_ci_ready(ready),
        .o_busy(busy3), .o_done(done3), .o_state(st3)
    );

    assign o_re   = sel ? re3   : re1;
    assign o_ra   = sel ? ra3   : ra1;
    assign o_rp   = sel ? rp3   : rp1;
    assign o_rpv  = sel ? rpv3  : rpv1;
    assign o_ci   = sel ? ci3   : ci1;
    assign o_civ  = sel ? civ3  : civ1;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_st   = sel ? st3   : st1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: data appears exactly RD_LAT cycles after the strobe, filler otherwise.
    always @(posedge clk) rd1 <= re1 ? mem[ra1] : FILL;
    always @(posedge clk) begin
        s1_3 <= re3 ? mem[ra3] : FILL;
        s2_3 <= s1_3;
        rd3  <= s2_3;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CIW-1:0] exp_ci(input int i);
        int w = i / 64;
        int k = i % 64;
        return (w == 0) ? CIW'(k % 16) : CIW'(15 - (k % 16));
    endfunction

    function automatic int seq_err(input int n);
        int e = 0;
        if (beats.size() != n) e++;
        for (int i = 0; i < beats.size() && i < n; i++)
            if (beats[i] !== exp_ci(i)) e++;
        return e;
    endfunction

    function automatic int rd_cyc_at(input int i);
        return (rd_cyc.size() > i) ? rd_cyc[i] : -1;
    endfunction

    function automatic int rd_addr_at(input int i);
        return (rd_addr.size() > i) ? rd_addr[i] : -1;
    endfunction

    // Cycle n is the cycle following edge n-1; i_start is sampled at edge 0.
    task automatic run_job(input int nnz, input bit rnd, input bit poke);
        bit             prev_stall;
        logic [CIW-1:0] prev_ci;
        prev_stall = 1'b0;
        prev_ci    = '0;
        beats.delete();
        rd_cyc.delete();
        rd_addr.delete();
        first_rpv  = -1;
        first_civ  = -1;
        done_cyc   = -1;
        civ_cycles = 0;
        nnz_in = CW'(nnz);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            start1 = 1'b0;
            start3 = 1'b0;
            if (prev_stall) begin
                check("hold_valid", o_civ, 1'b1);
                check("hold_col_idx", o_ci, prev_ci);
            end
            if (o_re) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(int'(o_ra));
            end
            if (o_rpv && first_rpv < 0) first_rpv = cyc;
            if (o_civ) begin
                civ_cycles++;
                if (first_civ < 0) first_civ = cyc;
            end
            ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (o_civ && ready) beats.push_back(o_ci);
            prev_stall = o_civ && !ready;
            prev_ci    = o_ci;
            if (poke && cyc == 2) begin
                nnz_in = CW'(7);
                if (sel) start3 = 1'b1; else start1 = 1'b1;
            end
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        start3 = 1'b0;
        ready  = 1'b1;
        if (done_cyc < 0) check("job_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] w;
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; ready = 1'b1; sel = 1'b0; nnz_in = '0;
        mem[0] = {32{8'hA5}};
        for (int k = 0; k < 64; k++) w[k*4 +: 4] = CIW'(k % 16);
        mem[1] = w;
        for (int k = 0; k < 64; k++) w[k*4 +: 4] = CIW'(15 - (k % 16));
        mem[2] = w;
        for (int i = 3; i < 32; i++) mem[i] = {8{32'(i)}};

        repeat (3) @(posedge clk); #1;
        check("rst_state1", st1, 0);
        check("rst_state3", st3, 0);
        check("rst_busy", busy1, 0);
        check("rst_rp_valid", rpv1, 0);
        check("rst_read_en", re1, 0);
        check("rst_row_ptr", rp3, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of streaming
        sel = 1'b0; nnz_in = CW'(70); start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_streaming", civ1, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_state", st1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_ci_valid", civ1, 0);
        check("mid_rst_col_idx", ci1, 0);
        check("mid_rst_rp_valid", rpv1, 0);
        check("mid_rst_row_ptr", rp1, 0);
        check("mid_rst_read_en", re1, 0);
        check("mid_rst_read_addr", ra1, 0);
        check("mid_rst_done", done1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_done", done1, 0);
        end

        // nnz=5, RD_LAT=1, always ready
        run_job(5, 1'b0, 1'b0);
        check("j5_reads", rd_cyc.size(), 2);
        check("j5_rp_addr", rd_addr_at(0), 0);
        check("j5_rp_cyc", rd_cyc_at(0), 1);
        check("j5_ci_addr", rd_addr_at(1), 1);
        check("j5_ci_cyc", rd_cyc_at(1), 3);
        check("j5_rpv_cyc", first_rpv, 3);
        check("j5_civ_cyc", first_civ, 5);
        check("j5_done_cyc", done_cyc, 10);
        check("j5_seq", seq_err(5), 0);
        check("j5_row_ptr", o_rp, EXP_RP);
        check("j5_rp_valid_hold", o_rpv, 1);

        // nnz=70 crosses into a second CI word
        run_job(70, 1'b0, 1'b0);
        check("j70_reads", rd_cyc.size(), 3);
        check("j70_addr2", rd_addr_at(2), 2);
        check("j70_refetch_cyc", rd_cyc_at(2), 69);
        check("j70_civ_cycles", civ_cycles, 70);
        check("j70_done_cyc", done_cyc, 77);
        check("j70_seq", seq_err(70), 0);

        // Random backpressure must give the same sequence
        run_job(70, 1'b1, 1'b0);
        check("bp_reads", rd_cyc.size(), 3);
        check("bp_addr2", rd_addr_at(2), 2);
        check("bp_seq", seq_err(70), 0);

        // nnz=0 with a start pulse while busy
        run_job(0, 1'b0, 1'b1);
        check("z_reads", rd_cyc.size(), 1);
        check("z_rp_addr", rd_addr_at(0), 0);
        check("z_rpv_cyc", first_rpv, 3);
        check("z_civ_cycles", civ_cycles, 0);
        check("z_done_cyc", done_cyc, 3);
        repeat (2) @(posedge clk);
        #1;
        check("z_idle_state", o_st, 0);
        check("z_idle_busy", o_busy, 0);
        check("z_rp_valid", o_rpv, 1);

        // RD_LAT=3, nnz=65
        sel = 1'b1;
        run_job(65, 1'b0, 1'b0);
        check("l3_reads", rd_cyc.size(), 3);
        check("l3_rp_cyc", rd_cyc_at(0), 1);
        check("l3_ci_cyc", rd_cyc_at(1), 5);
        check("l3_refetch_cyc", rd_cyc_at(2), 73);
        check("l3_rpv_cyc", first_rpv, 5);
        check("l3_civ_cyc", first_civ, 9);
        check("l3_civ_cycles", civ_cycles, 65);
        check("l3_done_cyc", done_cyc, 78);
        check("l3_seq", seq_err(65), 0);
        repeat (3) @(posedge clk);
        #1;
        check("l3_row_ptr_after", o_rp, EXP_RP);
        check("l3_rp_valid_after", o_rpv, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
